// File: rtl/mem_stack_controller_pkg.sv
// Shared types and constants for the memory/stack controller.
// FLAG_SAVE_EN adds the three-word INT/RTI frame (flags + PC) and FSM state W2.
package mem_stack_controller_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int PC_W   = 32;
    localparam int FLAG_W = 3;
    localparam logic [ADDR_W-1:0] STACK_TOP = 12'hFFF;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_PUSH  = 4'd3,
        OP_POP   = 4'd4,
        OP_CALL  = 4'd5,
        OP_RET   = 4'd6,
        OP_INT   = 4'd7,
        OP_RTI   = 4'd8
    } req_op_e;

`ifdef FLAG_SAVE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_W1 = 2'd1, S_W2 = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_W1 = 2'd1} state_e;
`endif

    // Unknown opcodes collapse to NONE; without flag saving INT/RTI alias CALL/RET.
    function automatic req_op_e decode_op(input logic [3:0] op);
        case (op)
            4'd1:    return OP_LOAD;
            4'd2:    return OP_STORE;
            4'd3:    return OP_PUSH;
            4'd4:    return OP_POP;
            4'd5:    return OP_CALL;
            4'd6:    return OP_RET;
`ifdef FLAG_SAVE_EN
            4'd7:    return OP_INT;
            4'd8:    return OP_RTI;
`else
            4'd7:    return OP_CALL;
            4'd8:    return OP_RET;
`endif
            default: return OP_NONE;
        endcase
    endfunction
endpackage

// File: rtl/mem_stack_controller_stack_pointer.sv
// Downward-growing stack pointer, modulo 4096, with sticky wrap error.
module stack_pointer
    import mem_stack_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_inc,
    input  logic [1:0]        i_step,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_sp_p1,
    output logic [ADDR_W-1:0] o_sp_p2,
    output logic              o_err
);
    logic [ADDR_W-1:0] r_sp;
    logic              r_err;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_step;
    logic              w_wrap;

    assign w_step = {{(ADDR_W-2){1'b0}}, i_step};
    assign w_sum  = {1'b0, r_sp} + {1'b0, w_step};
    // Carry out on increment, or a step larger than SP on decrement, means a wrap.
    assign w_wrap = i_inc ? w_sum[ADDR_W] : (w_step > r_sp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp  <= STACK_TOP;
            r_err <= 1'b0;
        end else if (i_en) begin
            r_sp  <= i_inc ? w_sum[ADDR_W-1:0] : (r_sp - w_step);
            r_err <= r_err | w_wrap;
        end
    end

    assign o_sp    = r_sp;
    assign o_sp_p1 = r_sp + 12'd1;
    assign o_sp_p2 = r_sp + 12'd2;
    assign o_err   = r_err;
endmodule

// File: rtl/mem_stack_controller.sv
// MEM-stage data-memory and stack controller: LOAD/STORE/PUSH/POP single-cycle,
// CALL/RET two-cycle, INT/RTI three-cycle when FLAG_SAVE_EN is defined.
module mem_stack_controller
    import mem_stack_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [15:0]       alu_addr,
    input  logic [15:0]       wr_data,
    input  logic [31:0]       pc_save,
    input  logic [2:0]        flags_in,
    input  logic [15:0]       dmem_rdata,
    output logic [11:0]       dmem_addr,
    output logic              dmem_we,
    output logic [15:0]       dmem_wdata,
    output logic              stall,
    output logic [15:0]       load_data,
    output logic [31:0]       pc_restore,
    output logic              pc_restore_valid,
    output logic [2:0]        flags_restore,
    output logic              flags_restore_valid,
    output logic [11:0]       sp_out,
    output logic              stack_err
);
    state_e            r_state, w_next;
    req_op_e           r_op, w_req_op;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_lo, r_load_data;
    logic [PC_W-1:0]   r_pc_restore;
    logic              r_pc_valid;
    logic [ADDR_W-1:0] w_sp, w_sp_p1, w_sp_p2, w_sp_m1;
    logic              w_sp_en, w_sp_inc;
    logic [1:0]        w_sp_step;
    logic              w_ld_en, w_lo_en, w_ret_done;

    assign w_req_op = req_valid ? decode_op(req_op) : OP_NONE;
    assign w_sp_m1  = w_sp - 12'd1;

    stack_pointer u_sp (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_sp_en),
        .i_inc   (w_sp_inc),
        .i_step  (w_sp_step),
        .o_sp    (w_sp),
        .o_sp_p1 (w_sp_p1),
        .o_sp_p2 (w_sp_p2),
        .o_err   (stack_err)
    );

`ifdef FLAG_SAVE_EN
    logic [DATA_W-1:0] r_hi;
    logic [FLAG_W-1:0] r_flags_restore;
    logic              r_flags_valid;
    logic              w_hi_en, w_rti_done;
    logic [ADDR_W-1:0] w_sp_m2, w_sp_p3;
    assign w_sp_m2 = w_sp - 12'd2;
    assign w_sp_p3 = w_sp + 12'd3;
`else
    logic w_unused;
    assign w_unused = ^{flags_in, r_pc[31:16], alu_addr[15:12]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        dmem_addr  = w_sp;
        dmem_we    = 1'b0;
        dmem_wdata = '0;
        stall      = 1'b0;
        w_sp_en    = 1'b0;
        w_sp_inc   = 1'b0;
        w_sp_step  = 2'd1;
        w_ld_en    = 1'b0;
        w_lo_en    = 1'b0;
        w_ret_done = 1'b0;
`ifdef FLAG_SAVE_EN
        w_hi_en    = 1'b0;
        w_rti_done = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                case (w_req_op)
                    OP_LOAD:  begin dmem_addr = alu_addr[11:0]; w_ld_en = 1'b1; end
                    OP_STORE: begin dmem_addr = alu_addr[11:0]; dmem_we = 1'b1; dmem_wdata = wr_data; end
                    OP_PUSH:  begin dmem_we = 1'b1; dmem_wdata = wr_data; w_sp_en = 1'b1; end
                    OP_POP:   begin dmem_addr = w_sp_p1; w_ld_en = 1'b1; w_sp_en = 1'b1; w_sp_inc = 1'b1; end
                    OP_CALL:  begin dmem_we = 1'b1; dmem_wdata = pc_save[31:16]; stall = 1'b1; w_next = S_W1; end
                    OP_RET:   begin dmem_addr = w_sp_p1; w_lo_en = 1'b1; stall = 1'b1; w_next = S_W1; end
`ifdef FLAG_SAVE_EN
                    OP_INT:   begin dmem_we = 1'b1; dmem_wdata = {13'b0, flags_in}; stall = 1'b1; w_next = S_W1; end
                    OP_RTI:   begin dmem_addr = w_sp_p1; w_lo_en = 1'b1; stall = 1'b1; w_next = S_W1; end
`endif
                    default: ;
                endcase
            end
            S_W1: begin
                w_next = S_IDLE;
                case (r_op)
                    OP_CALL: begin
                        dmem_addr = w_sp_m1; dmem_we = 1'b1; dmem_wdata = r_pc[15:0];
                        w_sp_en = 1'b1; w_sp_step = 2'd2;
                    end
                    OP_RET: begin
                        dmem_addr = w_sp_p2; w_ret_done = 1'b1;
                        w_sp_en = 1'b1; w_sp_inc = 1'b1; w_sp_step = 2'd2;
                    end
`ifdef FLAG_SAVE_EN
                    OP_INT: begin
                        dmem_addr = w_sp_m1; dmem_we = 1'b1; dmem_wdata = r_pc[31:16];
                        stall = 1'b1; w_next = S_W2;
                    end
                    OP_RTI: begin dmem_addr = w_sp_p2; w_hi_en = 1'b1; stall = 1'b1; w_next = S_W2; end
`endif
                    default: ;
                endcase
            end
`ifdef FLAG_SAVE_EN
            S_W2: begin
                w_next = S_IDLE;
                case (r_op)
                    OP_INT: begin
                        dmem_addr = w_sp_m2; dmem_we = 1'b1; dmem_wdata = r_pc[15:0];
                        w_sp_en = 1'b1; w_sp_step = 2'd3;
                    end
                    OP_RTI: begin
                        dmem_addr = w_sp_p3; w_rti_done = 1'b1;
                        w_sp_en = 1'b1; w_sp_inc = 1'b1; w_sp_step = 2'd3;
                    end
                    default: ;
                endcase
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // The request is latched every IDLE cycle so W1/W2 work from the held copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op         <= OP_NONE;
            r_pc         <= '0;
            r_lo         <= '0;
            r_load_data  <= '0;
            r_pc_restore <= '0;
            r_pc_valid   <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_op <= w_req_op;
                r_pc <= pc_save;
            end
            if (w_ld_en)    r_load_data  <= dmem_rdata;
            if (w_lo_en)    r_lo         <= dmem_rdata;
            if (w_ret_done) r_pc_restore <= {dmem_rdata, r_lo};
`ifdef FLAG_SAVE_EN
            if (w_rti_done) r_pc_restore <= {r_hi, r_lo};
            r_pc_valid <= w_ret_done | w_rti_done;
`else
            r_pc_valid <= w_ret_done;
`endif
        end
    end

`ifdef FLAG_SAVE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi            <= '0;
            r_flags_restore <= '0;
            r_flags_valid   <= 1'b0;
        end else begin
            if (w_hi_en)    r_hi            <= dmem_rdata;
            if (w_rti_done) r_flags_restore <= dmem_rdata[2:0];
            r_flags_valid <= w_rti_done;
        end
    end
    assign flags_restore       = r_flags_restore;
    assign flags_restore_valid = r_flags_valid;
`else
    assign flags_restore       = '0;
    assign flags_restore_valid = 1'b0;
`endif

    assign load_data        = r_load_data;
    assign pc_restore       = r_pc_restore;
    assign pc_restore_valid = r_pc_valid;
    assign sp_out           = w_sp;
endmodule

// File: tb/tb_mem_stack_controller.sv
// Directed bench for mem_stack_controller with a behavioural data memory.
module tb_mem_stack_controller;
    import mem_stack_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [15:0] alu_addr = '0;
    logic [15:0] wr_data = '0;
    logic [31:0] pc_save = '0;
    logic [2:0]  flags_in = '0;
    logic [15:0] dmem_rdata;
    logic [11:0] dmem_addr;
    logic        dmem_we;
    logic [15:0] dmem_wdata;
    logic        stall;
    logic [15:0] load_data;
    logic [31:0] pc_restore;
    logic        pc_restore_valid;
    logic [2:0]  flags_restore;
    logic        flags_restore_valid;
    logic [11:0] sp_out;
    logic        stack_err;

    logic [15:0] mem [0:4095];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) begin
        if (!reset) begin
            mem[12'h010] <= 16'hBEEF;
            mem[12'h000] <= 16'h7777;
        end else if (dmem_we) begin
            mem[dmem_addr] <= dmem_wdata;
        end
    end

    mem_stack_controller dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .alu_addr(alu_addr), .wr_data(wr_data), .pc_save(pc_save), .flags_in(flags_in),
        .dmem_rdata(dmem_rdata), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .stall(stall), .load_data(load_data),
        .pc_restore(pc_restore), .pc_restore_valid(pc_restore_valid),
        .flags_restore(flags_restore), .flags_restore_valid(flags_restore_valid),
        .sp_out(sp_out), .stack_err(stack_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input req_op_e op, input logic [15:0] a, input logic [15:0] d,
                         input logic [31:0] pc, input logic [2:0] fl);
        req_valid = 1'b1;
        req_op    = op;
        alu_addr  = a;
        wr_data   = d;
        pc_save   = pc;
        flags_in  = fl;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_op    = 4'd0;
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_sp", 32'(sp_out), 32'hFFF);
        check("rst_stall", 32'(stall), 0);
        check("rst_we", 32'(dmem_we), 0);
        check("rst_err", 32'(stack_err), 0);
        check("rst_ld", 32'(load_data), 0);
        check("rst_pcr", pc_restore, 0);
        check("rst_pcv", 32'(pc_restore_valid), 0);
        check("rst_flv", 32'(flags_restore_valid), 0);
        reset = 1'b1;
        tick();
        check("idle_addr", 32'(dmem_addr), 32'hFFF);

        // PUSH then POP
        drive(OP_PUSH, 16'h0, 16'h1234, 32'h0, 3'b0);
        check("push_stall", 32'(stall), 0);
        tick();
        check("push_mem", 32'(mem[12'hFFF]), 32'h1234);
        check("push_sp", 32'(sp_out), 32'hFFE);
        drive(OP_POP, 16'h0, 16'h0, 32'h0, 3'b0);
        check("pop_addr", 32'(dmem_addr), 32'hFFF);
        tick();
        idle();
        check("pop_data", 32'(load_data), 32'h1234);
        check("pop_sp", 32'(sp_out), 32'hFFF);

        // CALL then RET
        drive(OP_CALL, 16'h0, 16'h0, 32'h0001_00A0, 3'b0);
        check("call_stall0", 32'(stall), 1);
        check("call_we0", 32'(dmem_we), 1);
        tick();
        idle();
        check("call_stall1", 32'(stall), 0);
        check("call_addr1", 32'(dmem_addr), 32'hFFE);
        tick();
        check("call_hi", 32'(mem[12'hFFF]), 32'h0001);
        check("call_lo", 32'(mem[12'hFFE]), 32'h00A0);
        check("call_sp", 32'(sp_out), 32'hFFD);
        drive(OP_RET, 16'h0, 16'h0, 32'h0, 3'b0);
        check("ret_stall0", 32'(stall), 1);
        tick();
        idle();
        check("ret_stall1", 32'(stall), 0);
        check("ret_pcv_early", 32'(pc_restore_valid), 0);
        tick();
        check("ret_pc", pc_restore, 32'h0001_00A0);
        check("ret_pcv", 32'(pc_restore_valid), 1);
        check("ret_sp", 32'(sp_out), 32'hFFF);
        tick();
        check("ret_pcv_off", 32'(pc_restore_valid), 0);
        check("ret_pc_hold", pc_restore, 32'h0001_00A0);

        // LOAD, STORE, unrecognised op
        drive(OP_LOAD, 16'hF010, 16'h0, 32'h0, 3'b0);
        check("load_stall", 32'(stall), 0);
        check("load_addr", 32'(dmem_addr), 32'h010);
        tick();
        check("load_data", 32'(load_data), 32'hBEEF);
        drive(OP_STORE, 16'h0020, 16'h5A5A, 32'h0, 3'b0);
        tick();
        check("store_mem", 32'(mem[12'h020]), 32'h5A5A);
        check("store_ld_hold", 32'(load_data), 32'hBEEF);
        req_valid = 1'b1; req_op = 4'hF; #1;
        check("bad_we", 32'(dmem_we), 0);
        check("bad_addr", 32'(dmem_addr), 32'hFFF);
        tick();
        check("bad_sp", 32'(sp_out), 32'hFFF);

        // Underflow wrap then overflow wrap
        drive(OP_POP, 16'h0, 16'h0, 32'h0, 3'b0);
        tick();
        check("uf_sp", 32'(sp_out), 32'h000);
        check("uf_err", 32'(stack_err), 1);
        check("uf_data", 32'(load_data), 32'h7777);
        drive(OP_PUSH, 16'h0, 16'hABCD, 32'h0, 3'b0);
        tick();
        idle();
        check("of_sp", 32'(sp_out), 32'hFFF);
        check("of_mem", 32'(mem[12'h000]), 32'hABCD);
        check("err_sticky", 32'(stack_err), 1);

        // Reset in W1 of CALL
        drive(OP_CALL, 16'h0, 16'h0, 32'hDEAD_BEEF, 3'b0);
        tick();
        idle();
        reset = 1'b0;
        #1;
        check("mid_sp", 32'(sp_out), 32'hFFF);
        check("mid_stall", 32'(stall), 0);
        check("mid_we", 32'(dmem_we), 0);
        check("mid_err", 32'(stack_err), 0);
        tick();
        reset = 1'b1;
        tick();
        check("mid_partial_hi", 32'(mem[12'hFFF]), 32'hDEAD);
        check("mid_no_lo", 32'(mem[12'hFFE]), 32'h00A0);
        drive(OP_LOAD, 16'h0010, 16'h0, 32'h0, 3'b0);
        check("mid_load_stall", 32'(stall), 0);
        tick();
        idle();
        check("mid_load", 32'(load_data), 32'hBEEF);

`ifdef FLAG_SAVE_EN
        drive(OP_INT, 16'h0, 16'h0, 32'h0000_0020, 3'b101);
        check("int_stall0", 32'(stall), 1);
        check("int_wd0", 32'(dmem_wdata), 32'h0005);
        tick();
        idle();
        check("int_stall1", 32'(stall), 1);
        check("int_addr1", 32'(dmem_addr), 32'hFFE);
        tick();
        check("int_stall2", 32'(stall), 0);
        check("int_addr2", 32'(dmem_addr), 32'hFFD);
        tick();
        check("int_sp", 32'(sp_out), 32'hFFC);
        check("int_m0", 32'(mem[12'hFFF]), 32'h0005);
        check("int_m1", 32'(mem[12'hFFE]), 32'h0000);
        check("int_m2", 32'(mem[12'hFFD]), 32'h0020);
        drive(OP_RTI, 16'h0, 16'h0, 32'h0, 3'b0);
        check("rti_stall0", 32'(stall), 1);
        tick();
        idle();
        check("rti_stall1", 32'(stall), 1);
        tick();
        check("rti_stall2", 32'(stall), 0);
        tick();
        check("rti_pc", pc_restore, 32'h0000_0020);
        check("rti_fl", 32'(flags_restore), 32'h5);
        check("rti_pcv", 32'(pc_restore_valid), 1);
        check("rti_flv", 32'(flags_restore_valid), 1);
        check("rti_sp", 32'(sp_out), 32'hFFF);
`else
        drive(OP_INT, 16'h0, 16'h0, 32'h0030_0040, 3'b101);
        check("int_stall0", 32'(stall), 1);
        tick();
        idle();
        check("int_stall1", 32'(stall), 0);
        tick();
        check("int_sp", 32'(sp_out), 32'hFFD);
        check("int_hi", 32'(mem[12'hFFF]), 32'h0030);
        check("int_lo", 32'(mem[12'hFFE]), 32'h0040);
        drive(OP_RTI, 16'h0, 16'h0, 32'h0, 3'b0);
        tick();
        idle();
        tick();
        check("rti_pc", pc_restore, 32'h0030_0040);
        check("rti_pcv", 32'(pc_restore_valid), 1);
        check("rti_fl", 32'(flags_restore), 0);
        check("rti_flv", 32'(flags_restore_valid), 0);
        check("rti_sp", 32'(sp_out), 32'hFFF);
`endif
        check("final_ld_hold", 32'(load_data), 32'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stack_controller.md
MEM_STACK_CONTROLLER -- requirements
Module: mem_stack_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset.
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- req_valid  in  1  EX/MEM stage holds a memory request
- req_op  in  4  NONE, LOAD, STORE, PUSH, POP, CALL, RET, INT, RTI
- alu_addr  in  16  load/store address; bits [11:0] used
- wr_data  in  16  store/push data
- pc_save  in  32  PC to push for CALL/INT
- flags_in  in  3  carry, negative, zero, to save on INT
- dmem_rdata  in  16  data-memory read data, combinational from dmem_addr
- dmem_addr  out  12  data-memory address
- dmem_we  out  1  write strobe
- dmem_wdata  out  16  write data
- stall  out  1  freeze IF..EX/MEM while a multi-word op runs
- load_data  out  16  LOAD/POP result, registered
- pc_restore  out  32  popped PC, registered
- pc_restore_valid  out  1  one-cycle pulse
- flags_restore  out  3  popped flags, registered
- flags_restore_valid  out  1  one-cycle pulse
- sp_out  out  12  current stack pointer
- stack_err  out  1  sticky over/underflow

Function
REQ-003 The stack SHALL grow downward, with SP pointing at the next free word.
- Push: write mem[SP], then SP-1.
- Pop: read mem[SP+1], then SP+1.
REQ-004 SP arithmetic SHALL be modulo 4096.
- A push at SP=0x000 wraps to 0xFFF.
- A pop at SP=0xFFF wraps to 0x000.
- Either wrap sets stack_err; it stays set until reset.
REQ-005 LOAD SHALL read mem[alu_addr[11:0]] in the accept cycle, with load_data valid one cycle later and stall low.
REQ-006 STORE SHALL write wr_data to mem[alu_addr[11:0]] in the accept cycle, with stall low.
REQ-007 PUSH and POP SHALL complete in one cycle per REQ-003. POP data appears on load_data one cycle later, and stall stays low.
REQ-008 The FSM states SHALL be IDLE, W1 and W2. Requests are sampled only in IDLE; in W1/W2 the held req_op/inputs are used.
REQ-009 CALL SHALL take two cycles.
- IDLE cycle: write pc_save[31:16] at SP, stall=1, go to W1.
- W1 cycle: write pc_save[15:0] at SP-1, stall=0, SP-=2, go to IDLE.
REQ-010 RET SHALL take two cycles.
- IDLE cycle: read low word at SP+1 into a holding register, stall=1.
- W1 cycle: read high word at SP+2, stall=0, SP+=2.
- Next cycle: pc_restore={high,low} with pc_restore_valid=1.
REQ-011 stall SHALL be combinational: high in the accept cycle of any multi-word op and in every non-final cycle, and low in the final cycle.
REQ-012 dmem_we SHALL be 0 and dmem_addr SHALL equal SP when idle or when req_op=NONE.
REQ-013 An unrecognised req_op SHALL be treated as NONE.
REQ-014 load_data, pc_restore and flags_restore SHALL hold their values until the next corresponding completion.

Reset
REQ-015 On reset low, regardless of any operation in progress:
- state=IDLE, SP=0xFFF, stack_err=0, stall=0, dmem_we=0.
- All registered outputs and valid pulses are 0.
- Partially written stack words are not restored.

Configuration
REQ-016 The feature macro SHALL be FLAG_SAVE_EN.
- Defined: INT pushes {13'b0,flags_in} then PC high then PC low, taking 3 cycles (IDLE, W1, W2) with SP-=3. RTI pops PC low, PC high, then flags, taking 3 cycles with SP+=3. pc_restore_valid and flags_restore_valid pulse together one cycle after the last read.
- Undefined: INT behaves exactly as CALL and RTI exactly as RET. flags_restore and flags_restore_valid are tied to 0, and state W2 is removed.

Structure
REQ-017 A shared package SHALL hold the req_op enum, the state enum, STACK_TOP=12'hFFF, and the address/data width constants.
REQ-018 SP and stack_err SHALL live in a sub-module stack_pointer. It takes an increment/decrement enable and a step of 1..3, and outputs SP, SP+1 and SP+2.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then PUSH 0x1234 -> mem[0xFFF]=0x1234, SP=0xFFE; then POP -> load_data=0x1234 next cycle, SP=0xFFF.
- CALL pc_save=0x0001_00A0 at SP=0xFFF -> mem[0xFFF]=0x0001, mem[0xFFE]=0x00A0, stall high exactly 1 cycle, SP=0xFFD; RET -> pc_restore=0x000100A0 with a one-cycle valid pulse, SP=0xFFF.
- POP at SP=0xFFF -> SP=0x000 and stack_err=1 until reset; PUSH at SP=0x000 -> SP=0xFFF.
- FLAG_SAVE_EN: INT flags=3'b101, PC=0x20 -> three writes, stall high 2 cycles, SP-=3; RTI -> flags_restore=3'b101 and pc_restore=0x20 with both valids in the same cycle.
- Reset asserted in the W1 cycle of CALL -> SP=0xFFF, stall=0, FSM in IDLE; the next LOAD at 0x010 returns mem[0x010].
